// File: rtl/camera_power_seq_if.sv
// Request, SCCB-status and sensor-control signals of the camera power sequencer.
// The sequencer's state is carried alongside for debug and checker binding.
interface camera_power_seq_if;
    logic       pwr_down_req;
    logic       wake_req;
    logic       sccb_busy;
    logic       camera_pwnd;
    logic       camera_rstn;
    logic       sccb_hold;
    logic       cam_on;
    logic       seq_done;
    logic       sccb_timeout;
    logic [2:0] seq_state;

    // Requests are levels sampled every clock; there is no ready/ack, the
    // sequencer reports acceptance through its outputs and seq_done.
    modport master (
        output pwr_down_req, wake_req, sccb_busy,
        input  camera_pwnd, camera_rstn, sccb_hold, cam_on, seq_done, sccb_timeout, seq_state
    );

    modport slave (
        input  pwr_down_req, wake_req, sccb_busy,
        output camera_pwnd, camera_rstn, sccb_hold, cam_on, seq_done, sccb_timeout, seq_state
    );
endinterface

// File: rtl/camera_power_seq.sv
// Orderly camera sensor power-down / power-up sequencer: holds SCCB, waits for
// bus idle, then walks reset and power-down pins through timed phases.
module camera_power_seq #(
    parameter int T_QUIESCE    = 50000,
    parameter int T_RST        = 50000,
    parameter int T_PWDN       = 65536,
    parameter int SCCB_TIMEOUT = 250000
) (
    input logic              clk_50M,
    input logic              reset_n,
    camera_power_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ACTIVE, WAIT_IDLE, QUIESCE, RST_LOW, OFF, WAKE_PWDN, WAKE_RST
    } state_t;

    localparam logic [19:0] Q_END  = 20'(T_QUIESCE - 1);
    localparam logic [19:0] R_END  = 20'(T_RST - 1);
    localparam logic [19:0] P_END  = 20'(T_PWDN - 1);
    localparam logic [19:0] TO_END = 20'(SCCB_TIMEOUT - 1);

    state_t      state;
    logic [19:0] cnt;
    logic [3:0]  outs;   // {pwnd, rstn, hold, cam_on}
    logic        done_q;
    logic        timeout_q;
    logic        wake_armed;
    logic        pd_armed;
    logic        wake_go;
    logic        pd_go;

    function automatic logic [3:0] outs_for(input state_t s);
        logic [3:0] o;
        case (s)
            ACTIVE:                       o = 4'b0101;
            WAIT_IDLE, QUIESCE, WAKE_RST: o = 4'b0110;
            RST_LOW, WAKE_PWDN:           o = 4'b0010;
            default:                      o = 4'b1010;
        endcase
        return o;
    endfunction

    // A request is only accepted after it has been seen low since it was last
    // accepted, so a level held high cannot restart a sequence on its own.
    assign wake_go = (state == OFF) && bus.wake_req && wake_armed;
    assign pd_go   = (state == ACTIVE) && bus.pwr_down_req && pd_armed;

    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            state      <= OFF;
            cnt        <= '0;
            outs       <= outs_for(OFF);
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wake_armed <= 1'b1;
            pd_armed   <= 1'b1;
        end else begin
            done_q     <= 1'b0;
            cnt        <= cnt + 20'd1;
            wake_armed <= ~bus.wake_req | (wake_armed & ~wake_go);
            pd_armed   <= ~bus.pwr_down_req | (pd_armed & ~pd_go);
            case (state)
                ACTIVE: begin
                    cnt <= '0;
                    if (pd_go) begin
                        state     <= WAIT_IDLE;
                        outs      <= outs_for(WAIT_IDLE);
                        timeout_q <= 1'b0;
                    end
                end
                WAIT_IDLE: begin
                    // Idle takes priority over the timeout on the same cycle.
                    if (!bus.sccb_busy || cnt == TO_END) begin
                        state <= QUIESCE;
                        cnt   <= '0;
                        outs  <= outs_for(QUIESCE);
                        if (bus.sccb_busy) timeout_q <= 1'b1;
                    end
                end
                QUIESCE: begin
                    if (cnt == Q_END) begin
                        state <= RST_LOW;
                        cnt   <= '0;
                        outs  <= outs_for(RST_LOW);
                    end
                end
                RST_LOW: begin
                    if (cnt == R_END) begin
                        state  <= OFF;
                        cnt    <= '0;
                        outs   <= outs_for(OFF);
                        done_q <= 1'b1;
                    end
                end
                OFF: begin
                    cnt <= '0;
                    if (wake_go) begin
                        state <= WAKE_PWDN;
                        outs  <= outs_for(WAKE_PWDN);
                    end
                end
                WAKE_PWDN: begin
                    if (cnt == P_END) begin
                        state <= WAKE_RST;
                        cnt   <= '0;
                        outs  <= outs_for(WAKE_RST);
                    end
                end
                WAKE_RST: begin
                    if (cnt == R_END) begin
                        state  <= ACTIVE;
                        cnt    <= '0;
                        outs   <= outs_for(ACTIVE);
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= OFF;
                    cnt   <= '0;
                    outs  <= outs_for(OFF);
                end
            endcase
        end
    end

    assign {bus.camera_pwnd, bus.camera_rstn, bus.sccb_hold, bus.cam_on} = outs;
    assign bus.seq_done     = done_q;
    assign bus.sccb_timeout = timeout_q;
    assign bus.seq_state    = state;
endmodule

// File: tb/tb_camera_power_seq.sv
// Self-checking bench for camera_power_seq: directed scenarios plus random
// request/busy/reset traffic, compared each cycle against a timeline model.
module tb_camera_power_seq;
    localparam int T_QUIESCE    = 4;
    localparam int T_RST        = 3;
    localparam int T_PWDN       = 5;
    localparam int SCCB_TIMEOUT = 10;

    logic clk_50M = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk_50M = ~clk_50M;

    camera_power_seq_if bus();

    camera_power_seq #(
        .T_QUIESCE(T_QUIESCE), .T_RST(T_RST), .T_PWDN(T_PWDN), .SCCB_TIMEOUT(SCCB_TIMEOUT)
    ) dut (
        .clk_50M(clk_50M),
        .reset_n(reset_n),
        .bus(bus)
    );

    int    checks = 0;
    int    passed = 0;
    string phase  = "init";

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s/%s: got %b expected %b at %0t", phase, tag, obs, exp, $time);
    endtask

    // Reference model: steady OFF/ON, an idle-wait, or a precomputed script
    // of per-cycle pin values that ends in ON or OFF.
    typedef enum {M_OFF, M_ON, M_WAIT, M_SCRIPT} mode_t;
    mode_t      m_mode;
    logic [3:0] m_outs;
    logic       m_done;
    logic       m_to;
    int         m_wait;
    logic [3:0] script_q[$];
    bit         script_to_on;
    bit         w_ok;
    bit         p_ok;

    task automatic model_step(input logic w, input logic p, input logic b, input logic r);
        bit take_w;
        bit take_p;
        take_w = 0;
        take_p = 0;
        if (!r) begin
            m_mode = M_OFF; m_outs = 4'b1010; m_done = 0; m_to = 0;
            script_q.delete(); w_ok = 1; p_ok = 1;
        end else begin
            m_done = 0;
            case (m_mode)
                M_OFF: if (w && w_ok) begin
                    take_w = 1;
                    for (int i = 0; i < T_PWDN; i++) script_q.push_back(4'b0010);
                    for (int i = 0; i < T_RST; i++)  script_q.push_back(4'b0110);
                    script_to_on = 1;
                    m_outs = script_q.pop_front();
                    m_mode = M_SCRIPT;
                end
                M_ON: if (p && p_ok) begin
                    take_p = 1;
                    m_mode = M_WAIT; m_wait = 0; m_outs = 4'b0110; m_to = 0;
                end
                M_WAIT: begin
                    m_wait++;
                    if (!b || m_wait == SCCB_TIMEOUT) begin
                        if (b) m_to = 1;
                        for (int i = 0; i < T_QUIESCE; i++) script_q.push_back(4'b0110);
                        for (int i = 0; i < T_RST; i++)     script_q.push_back(4'b0010);
                        script_to_on = 0;
                        m_outs = script_q.pop_front();
                        m_mode = M_SCRIPT;
                    end
                end
                default: begin
                    if (script_q.size() == 0) begin
                        m_done = 1;
                        if (script_to_on) begin m_mode = M_ON;  m_outs = 4'b0101; end
                        else              begin m_mode = M_OFF; m_outs = 4'b1010; end
                    end else begin
                        m_outs = script_q.pop_front();
                    end
                end
            endcase
            if (!w) w_ok = 1; else if (take_w) w_ok = 0;
            if (!p) p_ok = 1; else if (take_p) p_ok = 0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1 ns later.
    task automatic cyc(input logic w, input logic p, input logic b, input logic r);
        bus.wake_req = w; bus.pwr_down_req = p; bus.sccb_busy = b; reset_n = r;
        @(posedge clk_50M);
        model_step(w, p, b, r);
        #1;
        check("outs",
              {2'b00, bus.camera_pwnd, bus.camera_rstn, bus.sccb_hold, bus.cam_on, bus.seq_done, bus.sccb_timeout},
              {2'b00, m_outs, m_done, m_to});
        check("rstn_and_pwnd", {7'd0, bus.camera_rstn & bus.camera_pwnd}, 8'h00);
        check("rstn_low_no_hold", {7'd0, ~bus.camera_rstn & ~bus.sccb_hold}, 8'h00);
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) cyc(0, 0, b, 1);
    endtask

    // Bounded wait for the sensor to come up; expiry counts as a failure.
    task automatic run_until_on(input int limit);
        int k;
        k = 0;
        while (bus.cam_on !== 1'b1 && k < limit) begin
            cyc(0, 0, 0, 1);
            k++;
        end
        check("reach_active", {7'd0, bus.cam_on}, 8'h01);
    endtask

    task automatic wake_up();
        cyc(1, 0, 0, 1);
        run_until_on(20);
        idle(2, 0);
    endtask

    logic rw = 1'b0, rp = 1'b0, rb = 1'b0, rr = 1'b1;

    initial begin
        phase = "reset";
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        idle(4, 0);

        phase = "wake";
        cyc(1, 0, 0, 1);
        idle(12, 0);

        phase = "pd_idle";
        cyc(0, 1, 0, 1);
        idle(14, 0);

        phase = "pd_timeout";
        wake_up();
        cyc(0, 1, 1, 1);
        idle(20, 1);
        idle(3, 0);
        wake_up();
        idle(3, 0);
        cyc(0, 1, 0, 1);
        idle(12, 0);

        phase = "pd_late_idle";
        wake_up();
        cyc(0, 1, 1, 1);
        idle(2, 1);
        cyc(0, 0, 0, 1);
        idle(12, 0);

        phase = "timeout_tie";
        wake_up();
        cyc(0, 1, 1, 1);
        idle(9, 1);
        cyc(0, 0, 0, 1);
        idle(12, 0);

        phase = "ignored_reqs";
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(1, 1, 0, 1);
        idle(10, 0);
        cyc(0, 1, 0, 1);
        idle(2, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        idle(14, 0);

        phase = "held_levels";
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 1);
        for (int i = 0; i < 25; i++) cyc(1, 1, 0, 1);
        idle(3, 0);

        phase = "reset_in_rst_low";
        wake_up();
        cyc(0, 1, 0, 1);
        idle(5, 0);
        idle(1, 0);
        cyc(0, 0, 0, 0);
        idle(5, 0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rw = ~rw;
            if ($urandom_range(0, 9) == 0) rp = ~rp;
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            rr = ($urandom_range(0, 399) != 0);
            cyc(rw, rp, rb, rr);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
